// File: rtl/bus_gnrtr_n_arbiter.sv
// Shared-bus generator with a round-robin arbiter per bus.
// Each bus takes one packet at a time from the pending source FIFOs and
// delivers it to the terminal named by the packet's top byte. A broadcast ID
// sends it to every terminal except the source.
module bus_gnrtr_n_arbiter #(
    parameter int          bits      = 1,
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [bits-1:0][drvrs-1:0]                  pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]     D_pop,
    output logic [bits-1:0][drvrs-1:0]                  pop,
    output logic [bits-1:0][drvrs-1:0]                  push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]     D_push
);

    localparam int PW = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_POP  = 2'd1,
        ST_PUSH = 2'd2
    } state_t;

    // First requester at or above ptr, wrapping from drvrs-1 back to 0.
    function automatic logic [PW-1:0] rr_pick(input logic [drvrs-1:0] req,
                                              input logic [PW-1:0]    ptr);
        logic [PW-1:0] win;
        logic          found;
        logic [PW:0]   idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < drvrs; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(drvrs)) begin
                idx = idx - (PW+1)'(drvrs);
            end else begin
                idx = idx;
            end
            if (!found && req[idx[PW-1:0]]) begin
                win   = idx[PW-1:0];
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

    for (genvar b = 0; b < bits; b++) begin : g_bus
        state_t             state_q, state_d;
        logic [PW-1:0]      ptr_q, ptr_d;
        logic [PW-1:0]      src_q, src_d;
        logic [pckg_sz-1:0] data_q, data_d;
        logic [pckg_sz-1:0] dpush_q, dpush_d;
        logic [drvrs-1:0]   pop_q, pop_d;
        logic [drvrs-1:0]   push_q, push_d;
        logic [drvrs-1:0]   uni_mask_s;
        logic [drvrs-1:0]   bcast_mask_s;
        logic [7:0]         id_s;
        logic [PW-1:0]      win_s;

        // Destination decode of the captured packet: unicast and broadcast masks.
        always_comb begin
            id_s         = data_q[pckg_sz-1 -: 8];
            uni_mask_s   = '0;
            bcast_mask_s = '0;
            for (int k = 0; k < drvrs; k++) begin
                uni_mask_s[k]   = (id_s == 8'(k));
                bcast_mask_s[k] = (PW'(k) != src_q);
            end
        end

        // Next-state and next-output computation for this bus.
        always_comb begin
            state_d = state_q;
            ptr_d   = ptr_q;
            src_d   = src_q;
            data_d  = data_q;
            dpush_d = dpush_q;
            pop_d   = '0;
            push_d  = '0;
            win_s   = rr_pick(pndng[b], ptr_q);
            case (state_q)
                ST_ARB: begin
                    if (|pndng[b]) begin
                        pop_d[win_s] = 1'b1;
                        data_d       = D_pop[b][win_s];
                        src_d        = win_s;
                        state_d      = ST_POP;
                    end else begin
                        state_d      = ST_ARB;
                    end
                end
                ST_POP: begin
                    dpush_d = data_q;
                    if (id_s == broadcast) begin
                        push_d = bcast_mask_s;
                    end else if (id_s < 8'(drvrs)) begin
                        push_d = uni_mask_s;
                    end else begin
                        push_d = '0;
                    end
                    state_d = ST_PUSH;
                end
                ST_PUSH: begin
                    if (src_q == PW'(drvrs - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = src_q + PW'(1);
                    end
                    state_d = ST_ARB;
                end
                default: begin
                    state_d = ST_ARB;
                end
            endcase
        end

        // Bus FSM state and registered strobes/data; reset drops any in-flight packet.
        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q <= ST_ARB;
                ptr_q   <= '0;
                src_q   <= '0;
                data_q  <= '0;
                dpush_q <= '0;
                pop_q   <= '0;
                push_q  <= '0;
            end else begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                src_q   <= src_d;
                data_q  <= data_d;
                dpush_q <= dpush_d;
                pop_q   <= pop_d;
                push_q  <= push_d;
            end
        end

        assign pop[b]  = pop_q;
        assign push[b] = push_q;
        for (genvar k = 0; k < drvrs; k++) begin : g_dout
            assign D_push[b][k] = dpush_q;
        end
    end

endmodule

// File: tb/tb_bus_gnrtr_n_arbiter.sv
// Directed bench for bus_gnrtr_n_arbiter (bits=1, drvrs=4, pckg_sz=16).
// A transaction-level model predicts pop/push/D_push every cycle; a few
// literal expectations pin the model on the documented scenarios.
module tb_bus_gnrtr_n_arbiter;

    logic                    clk;
    logic                    reset;
    logic [0:0][3:0]         pndng;
    logic [0:0][3:0][15:0]   D_pop;
    logic [0:0][3:0]         pop;
    logic [0:0][3:0]         push;
    logic [0:0][3:0][15:0]   D_push;

    bus_gnrtr_n_arbiter #(
        .bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // model state
    int          m_ptr  = 0;
    int          m_busy = 0;
    logic [3:0]  exp_pop  = 4'h0;
    logic [3:0]  exp_push = 4'h0;
    logic [15:0] exp_d    = 16'h0;
    logic [3:0]  nxt_push = 4'h0;
    logic [15:0] nxt_d    = 16'h0;
    bit          nxt_dv   = 1'b0;

    // source FIFO emulation for the round-robin scenario
    bit          fifo_mode = 1'b0;
    int          cnt [4];
    int          pop_idx [$];
    int          pop_cyc [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] dest_mask(input logic [7:0] id, input int src);
        if (id == 8'hFF) return 4'hF & ~(4'h1 << src);
        else if (id < 8'd4) return 4'h1 << id;
        else return 4'h0;
    endfunction

    function automatic logic [15:0] fifo_word(input int i, input int n);
        logic [7:0] id;
        logic [7:0] pl;
        id = 8'((i + n + 2) % 5);
        pl = 8'(i * 16 + n);
        return {id, pl};
    endfunction

    // Model: a packet granted at an edge pops on that edge, pushes on the next,
    // and the bus may grant again three edges after the grant.
    task automatic model_edge();
        int w;
        int c;
        if (!reset) begin
            m_ptr = 0; m_busy = 0;
            exp_pop = 4'h0; exp_push = 4'h0; exp_d = 16'h0;
            nxt_push = 4'h0; nxt_dv = 1'b0;
        end else begin
            exp_pop  = 4'h0;
            exp_push = nxt_push;
            nxt_push = 4'h0;
            if (nxt_dv) exp_d = nxt_d;
            nxt_dv = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
            end else if (pndng[0] != 4'h0) begin
                w = -1;
                for (int k = 0; k < 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (w < 0 && pndng[0][c]) w = c;
                end
                exp_pop  = 4'h1 << w;
                nxt_d    = D_pop[0][w];
                nxt_dv   = 1'b1;
                nxt_push = dest_mask(D_pop[0][w][15:8], w);
                m_ptr    = (w + 1) % 4;
                m_busy   = 2;
            end
        end
    endtask

    task automatic drive_fifos();
        for (int i = 0; i < 4; i++) begin
            pndng[0][i] = (cnt[i] > 0);
            D_pop[0][i] = (cnt[i] > 0) ? fifo_word(i, 2 - cnt[i]) : 16'h0000;
        end
    endtask

    // One clock: model advances on the edge, outputs are compared mid-cycle.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chk("pop", {28'h0, pop[0]}, {28'h0, exp_pop});
        chk("push", {28'h0, push[0]}, {28'h0, exp_push});
        for (int k = 0; k < 4; k++) chk("d_push", {16'h0, D_push[0][k]}, {16'h0, exp_d});
        if (fifo_mode) begin
            for (int i = 0; i < 4; i++) begin
                if (pop[0][i]) begin
                    pop_idx.push_back(i);
                    pop_cyc.push_back(cyc);
                    if (cnt[i] > 0) cnt[i]--;
                end
            end
            drive_fifos();
        end
    endtask

    initial begin
        int ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int budget;
        reset = 1'b0;
        pndng = '0;
        D_pop = '0;

        // reset held with all sources pending
        pndng[0] = 4'hF;
        D_pop[0][0] = 16'h0155;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_pop", {28'h0, pop[0]}, 32'h0);
            chk("rst_push", {28'h0, push[0]}, 32'h0);
            chk("rst_dpush", {16'h0, D_push[0][0]}, 32'h0);
        end
        reset = 1'b1;
        tick();
        chk("first_pop_t0", {28'h0, pop[0]}, 32'h1);
        pndng[0] = 4'h0;
        repeat (3) tick();

        // unicast to terminal 3
        pndng[0] = 4'b0010; D_pop[0][1] = 16'h0312;
        tick();
        chk("uni_pop", {28'h0, pop[0]}, 32'h2);
        pndng[0] = 4'h0;
        tick();
        chk("uni_pop_off", {28'h0, pop[0]}, 32'h0);
        chk("uni_push", {28'h0, push[0]}, 32'h8);
        chk("uni_data", {16'h0, D_push[0][2]}, 32'h0312);
        tick();
        chk("uni_push_off", {28'h0, push[0]}, 32'h0);
        tick();

        // broadcast from terminal 2
        pndng[0] = 4'b0100; D_pop[0][2] = 16'hFFAB;
        tick();
        chk("bc_pop", {28'h0, pop[0]}, 32'h4);
        pndng[0] = 4'h0;
        tick();
        chk("bc_push", {28'h0, push[0]}, 32'hB);
        chk("bc_data", {16'h0, D_push[0][0]}, 32'hFFAB);
        repeat (2) tick();

        // invalid ID: popped but never pushed
        pndng[0] = 4'b0001; D_pop[0][0] = 16'h07CC;
        tick();
        chk("inv_pop", {28'h0, pop[0]}, 32'h1);
        pndng[0] = 4'h0;
        tick();
        chk("inv_push", {28'h0, push[0]}, 32'h0);
        repeat (2) tick();

        // round robin over four sources with two packets each, from reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cnt[i] = 2;
        fifo_mode = 1'b1;
        drive_fifos();
        budget = 0;
        while ((cnt[0] + cnt[1] + cnt[2] + cnt[3]) > 0 && budget < 60) begin
            tick();
            budget++;
        end
        if (budget >= 60) chk("rr_timeout", 32'(budget), 32'd0);
        repeat (3) tick();
        fifo_mode = 1'b0;
        pndng[0] = 4'h0;
        chk("rr_count", 32'(pop_idx.size()), 32'd8);
        for (int i = 0; i < 8 && i < pop_idx.size(); i++) begin
            chk("rr_order", 32'(pop_idx[i]), 32'(ord[i]));
            if (i > 0) chk("rr_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd3);
        end
        tick();

        // reset during POP discards the packet and clears the pointer
        pndng[0] = 4'b0100; D_pop[0][2] = 16'h0112;
        tick();
        chk("rp_pop", {28'h0, pop[0]}, 32'h4);
        pndng[0] = 4'h0;
        reset = 1'b0;
        tick();
        chk("rp_push", {28'h0, push[0]}, 32'h0);
        chk("rp_pop_off", {28'h0, pop[0]}, 32'h0);
        chk("rp_data", {16'h0, D_push[0][1]}, 32'h0);
        reset = 1'b1;
        tick();
        chk("rp_idle", {28'h0, push[0]}, 32'h0);
        pndng[0] = 4'b1001; D_pop[0][0] = 16'h0255; D_pop[0][3] = 16'h0166;
        tick();
        chk("rp_ptr0", {28'h0, pop[0]}, 32'h1);
        pndng[0] = 4'h0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
